// File: rtl/ppu_pkg.sv
// Shared types for the PPU sprite evaluator: OAM word layout, slot record, FSM states.
// The PPU_SPRITE_TALL_EN macro (see sprite_hit_check) enables 16-row sprites.
package ppu_pkg;

  localparam int OAM_W  = 32;
  localparam int X_W    = 9;
  localparam int TILE_W = 8;
  localparam int ROW_W  = 4;
  localparam int ATTR_W = 5;
  localparam int PAL_W  = 3;

  // Field order matches the OAM word from bit 31 down to bit 0.
  typedef struct packed {
    logic              enable;
    logic              behind_bg;
    logic              vflip;
    logic              hflip;
    logic [PAL_W-1:0]  palette;
    logic [TILE_W-1:0] tile;
    logic [X_W-1:0]    x;
    logic [7:0]        y;
  } oam_entry_t;

  typedef struct packed {
    logic              valid;
    logic [X_W-1:0]    x;
    logic [TILE_W-1:0] tile;
    logic [ROW_W-1:0]  row;
    logic [ATTR_W-1:0] attr;
  } slot_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } eval_state_t;

  function automatic logic [ATTR_W-1:0] slot_attr_of(input oam_entry_t e);
    return {e.behind_bg, e.hflip, e.palette};
  endfunction

endpackage

// File: rtl/ppu_sprite_eval_if.sv
// Bus between the sprite evaluator, its OAM port and the shift-register loader.
interface ppu_sprite_eval_if #(
  parameter int OAM_ENTRIES = 64,
  parameter int SLOTS       = 8,
  parameter int Y_W         = 8
);
  localparam int AW = $clog2(OAM_ENTRIES);
  localparam int CW = $clog2(SLOTS + 1);

  logic                  start;
  logic [Y_W-1:0]        line;
  logic                  tall_mode;
  logic [AW-1:0]         oam_addr;
  logic [31:0]           oam_rd_data;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [CW-1:0]         slot_count;
  logic [SLOTS-1:0]      slot_valid;
  logic [SLOTS-1:0][8:0] slot_x;
  logic [SLOTS-1:0][7:0] slot_tile;
  logic [SLOTS-1:0][3:0] slot_row;
  logic [SLOTS-1:0][4:0] slot_attr;

  modport master (
    output start, line, tall_mode, oam_rd_data,
    input  oam_addr, busy, done, overflow, slot_count,
           slot_valid, slot_x, slot_tile, slot_row, slot_attr
  );

  modport slave (
    input  start, line, tall_mode, oam_rd_data,
    output oam_addr, busy, done, overflow, slot_count,
           slot_valid, slot_x, slot_tile, slot_row, slot_attr
  );
endinterface

// File: rtl/sprite_hit_check.sv
// Combinational scanline hit test and row select for one OAM entry.
// PPU_SPRITE_TALL_EN defined: tall_mode selects 16-row sprites; otherwise height is fixed at 8.
module sprite_hit_check
  import ppu_pkg::*;
#(
  parameter int Y_W = 8
) (
  input  logic [Y_W-1:0]   line_i,
  input  logic             tall_mode_i,
  input  oam_entry_t       entry_i,
  output logic             hit_o,
  output logic [ROW_W-1:0] row_o
);
  logic             tall;
  logic [Y_W-1:0]   diff;
  logic [ROW_W-1:0] raw_row;
  logic             unused_fields;

`ifdef PPU_SPRITE_TALL_EN
  assign tall = tall_mode_i;
`else
  logic unused_tall;
  assign unused_tall = tall_mode_i;
  assign tall        = 1'b0;
`endif

  assign unused_fields = ^{entry_i.x, entry_i.tile, entry_i.palette,
                           entry_i.hflip, entry_i.behind_bg};

  // Modular subtraction lets sprites near the bottom wrap onto lines 0.. .
  always_comb begin
    diff    = line_i - Y_W'(entry_i.y);
    hit_o   = entry_i.enable && (tall ? ((diff >> 4) == '0) : ((diff >> 3) == '0));
    raw_row = tall ? diff[3:0] : {1'b0, diff[2:0]};
    row_o   = raw_row;
    if (entry_i.vflip) row_o = tall ? ~raw_row : {1'b0, ~raw_row[2:0]};
  end
endmodule

// File: rtl/ppu_sprite_eval.sv
// Per-scanline sprite evaluator: scans OAM in hblank, fills a shadow slot set, commits it atomically.
// PPU_SPRITE_TALL_EN enables 16-row sprites (handled in sprite_hit_check).
module ppu_sprite_eval
  import ppu_pkg::*;
#(
  parameter int OAM_ENTRIES = 64,
  parameter int SLOTS       = 8,
  parameter int Y_W         = 8
) (
  input logic               clk,
  input logic               reset_n,
  ppu_sprite_eval_if.slave  bus
);
  localparam int AW = $clog2(OAM_ENTRIES);
  localparam int CW = $clog2(SLOTS + 1);

  eval_state_t          state_q, state_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [Y_W-1:0]       line_q;
  logic                 tall_q;
  logic                 eval_q;
  slot_t [SLOTS-1:0]    shadow_q, shadow_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q, ovf_d;
  slot_t [SLOTS-1:0]    pub_q;
  logic [CW-1:0]        pub_count_q;
  logic                 pub_ovf_q;
  logic                 done_q;
  logic                 start_ok;
  logic                 hit;
  logic [ROW_W-1:0]     row;
  oam_entry_t           entry;
  slot_t                new_slot;

  // COMMIT is not IDLE, so a start coinciding with it is dropped here too.
  assign start_ok = (state_q == IDLE) && bus.start;
  assign entry    = oam_entry_t'(bus.oam_rd_data);

  sprite_hit_check #(.Y_W(Y_W)) u_hit (
    .line_i      (line_q),
    .tall_mode_i (tall_q),
    .entry_i     (entry),
    .hit_o       (hit),
    .row_o       (row)
  );

  // NOTE: every variable driven here gets a default first, so no path leaves a latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      IDLE: if (start_ok) begin
        state_d = SCAN;
        addr_d  = '0;
      end
      SCAN: begin
        if (addr_q == AW'(OAM_ENTRIES - 1)) state_d = DRAIN;
        else                                addr_d  = addr_q + AW'(1);
      end
      DRAIN:   state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    new_slot = '{valid: 1'b1, x: entry.x, tile: entry.tile, row: row,
                 attr: slot_attr_of(entry)};
    shadow_d = shadow_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (start_ok) begin
      shadow_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else if (eval_q && hit) begin
      if (count_q == CW'(SLOTS)) begin
        ovf_d = 1'b1;
      end else begin
        for (int s = 0; s < SLOTS; s++)
          if (count_q == CW'(s)) shadow_d[s] = new_slot;
        count_d = count_q + CW'(1);
      end
    end
  end

  // NOTE: the shadow and published slot sets are plain flops that must read as zero
  // straight out of reset, so they sit in the reset branch rather than being left as RAM.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      line_q      <= '0;
      tall_q      <= 1'b0;
      eval_q      <= 1'b0;
      shadow_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      pub_q       <= '0;
      pub_count_q <= '0;
      pub_ovf_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      addr_q   <= addr_d;
      eval_q   <= (state_q == SCAN);
      shadow_q <= shadow_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      done_q   <= (state_q == DRAIN);
      if (start_ok) begin
        line_q <= bus.line;
        tall_q <= bus.tall_mode;
      end
      // Publish including the last word so results appear together with done.
      if (state_q == DRAIN) begin
        pub_q       <= shadow_d;
        pub_count_q <= count_d;
        pub_ovf_q   <= ovf_d;
      end
    end
  end

  assign bus.oam_addr   = addr_q;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done_q;
  assign bus.overflow   = pub_ovf_q;
  assign bus.slot_count = pub_count_q;

  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      bus.slot_valid[s] = pub_q[s].valid;
      bus.slot_x[s]     = pub_q[s].x;
      bus.slot_tile[s]  = pub_q[s].tile;
      bus.slot_row[s]   = pub_q[s].row;
      bus.slot_attr[s]  = pub_q[s].attr;
    end
  end
endmodule

// File: doc/ppu_sprite_eval.md
# ppu_sprite_eval

Per-scanline sprite evaluator for the PPU. During horizontal blank it scans every OAM entry, selects up to SLOTS sprites that intersect the next scanline in OAM order, and publishes their per-slot attributes to the sprite shift-register loader. It is a parametrised successor to the fixed eight-sprite path: OAM depth, slot count and sprite height are configurable, and it adds overflow detection, vertical flip and double-buffered results.

## Interface
- OAM_ENTRIES, 64: number of 32-bit OAM words scanned; power of two, 8..256.
- SLOTS, 8: maximum sprites per line; 1..16.
- Y_W, 8: scanline and sprite Y width.
- clk  in  1  PPU clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse at hblank start; ignored while busy.
- line  in  Y_W  scanline to evaluate; sampled with start.
- tall_mode  in  1  1 = 16-row sprites, 0 = 8-row; sampled with start.
- oam_addr  out  $clog2(OAM_ENTRIES)  OAM read address; reset 0.
- oam_rd_data  in  32  OAM read data, one-cycle synchronous latency.
- busy  out  1  scan in progress; reset 0.
- done  out  1  one-cycle pulse when results commit; reset 0.
- overflow  out  1  more than SLOTS hits on committed line; reset 0.
- slot_count  out  $clog2(SLOTS+1)  valid slots on committed line; reset 0.
- slot_valid  out  SLOTS  per-slot valid; reset 0.
- slot_x  out  SLOTS x 9  sprite X; reset 0.
- slot_tile  out  SLOTS x 8  tile index; reset 0.
- slot_row  out  SLOTS x 4  row within sprite after vflip; reset 0.
- slot_attr  out  SLOTS x 5  {behind_bg, hflip, palette[2:0]}; reset 0.

## Operation
- OAM word: [7:0] y, [16:8] x, [24:17] tile, [27:25] palette, [28] hflip, [29] vflip, [30] behind_bg, [31] enable.
- FSM: IDLE -> SCAN on start; SCAN issues addresses 0..OAM_ENTRIES-1 one per cycle; DRAIN evaluates the last returned word; COMMIT copies shadow set to outputs, pulses done; -> IDLE.
- Hit test: diff = line - y modulo 2^Y_W (wraps, so sprites at y near 255 cover lines 0..); hit = enable && diff < height, height = 16 if tall_mode else 8.
- Row: diff[3:0] (8-row: diff[2:0] zero-extended); vflip gives height-1-diff.
- Hits fill shadow slots 0,1,2... in ascending OAM index; lower index = higher priority.
- Hit with shadow full: no slot write, shadow overflow set; scan continues to end.
- Shadow cleared on start; published outputs unchanged until COMMIT (renderer may read them throughout the scan).
- start while busy: ignored, no restart. start and COMMIT in the same cycle: start ignored.
- reset_n low at any time: FSM to IDLE, all outputs and shadow to reset values immediately.

## Timing
- Cycle 0: start sampled. Cycle 1+i: oam_addr = i, busy = 1. Cycle 2+i: word i evaluated, shadow updated at end of cycle.
- Cycle OAM_ENTRIES+2: COMMIT; done = 1, outputs updated at that edge; busy falls the following cycle.
- Start-to-done latency OAM_ENTRIES+2 cycles; back-to-back start accepted the cycle after done.
- oam_addr holds last value in IDLE.

## Configuration
- PPU_SPRITE_TALL_EN defined: tall_mode honoured, 16-row sprites, 4-bit row.
- Undefined: tall_mode ignored, height fixed 8, slot_row[3] tied 0, vflip mirrors over 8 rows.

## Structure
- ppu_pkg: oam_entry_t packed struct, slot_t struct, eval_state_t enum (IDLE, SCAN, DRAIN, COMMIT), field-width constants.
- Sub-module sprite_hit_check: combinational hit/row computation for one entry (line, tall_mode, entry -> hit, row).

## Test plan
- Entry 3 = y 20, x 100, tile 7, enable; line 25 -> done at cycle 66, slot_count 1, slot 0 {x 100, tile 7, row 5}, overflow 0.
- Ten enabled entries all y 10, line 10, SLOTS 8 -> slots hold entries 0..7, slot_count 8, overflow 1.
- Entry y 250, tall_mode 1, line 4 -> hit, row 10; tall_mode 0 -> no hit (diff 10 >= 8).
- vflip entry y 0, line 2, tall_mode 0 -> row 5; enable=0 same entry -> no hit.
- Second start pulsed at cycle 30 of a scan -> ignored, done still at cycle 66, outputs from first line only.
- reset_n low at cycle 40 -> busy, done, slot_valid, slot_count, overflow 0 immediately; no done pulse after release.
